// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared register-file widths and the x0 index constant.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int DATA_WIDTH     = 32;
    localparam int REG_NUM        = 32;

    localparam logic [REG_ADDR_WIDTH-1:0] X0_IDX = '0;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter_if
// Description : Write-back request, issue allocation, source check and
//               register-file write signals of the write-back arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_wb_arbiter_if
    import rf_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = REG_ADDR_WIDTH,
    parameter int DATA_W = DATA_WIDTH
);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*ADDR_W-1:0] req_rd;
    logic [N_REQ*DATA_W-1:0] req_data;

    logic                    iss_valid;
    logic [ADDR_W-1:0]       iss_rd;
    logic                    iss_ready;

    logic [ADDR_W-1:0]       rs1;
    logic [ADDR_W-1:0]       rs2;
    logic                    rs1_busy;
    logic                    rs2_busy;

    logic                    rf_wen;
    logic [ADDR_W-1:0]       rf_waddr;
    logic [DATA_W-1:0]       rf_wdata;

    modport master (
        output req_valid, req_rd, req_data,
        output iss_valid, iss_rd, rs1, rs2,
        input  req_ready, iss_ready, rs1_busy, rs2_busy,
        input  rf_wen, rf_waddr, rf_wdata
    );

    modport slave (
        input  req_valid, req_rd, req_data,
        input  iss_valid, iss_rd, rs1, rs2,
        output req_ready, iss_ready, rs1_busy, rs2_busy,
        output rf_wen, rf_waddr, rf_wdata
    );

endinterface : rf_wb_arbiter_if
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter with a registered priority
//               pointer that moves past the last winner.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic [N-1:0] req,
    output logic      [N-1:0] grant,
    input  wire logic         advance
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] r_rr_ptr;
    logic [PTR_W-1:0] w_win_idx;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic             w_found;
    int               w_best_dist;
    int               w_dist;

    // Winner is the valid requester closest to the pointer, counting upward
    // with wrap-around.
    always_comb begin
        w_win_idx   = '0;
        w_found     = 1'b0;
        w_best_dist = N;
        w_dist      = 0;
        for (int i = 0; i < N; i++) begin
            w_dist = (i - int'(r_rr_ptr) + N) % N;
            if (req[i] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                w_win_idx   = PTR_W'(i);
                w_found     = 1'b1;
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = w_found && (w_win_idx == PTR_W'(i));
        end
    end

    assign w_ptr_nxt = (int'(w_win_idx) == N - 1) ? '0 : w_win_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (advance && w_found) begin
            r_rr_ptr <= w_ptr_nxt;
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Shares the register-file write port among write-back sources
//               and keeps a per-register pending-write scoreboard for issue.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
    parameter int REG_ADDR_WIDTH = rf_pkg::REG_ADDR_WIDTH,
    parameter int DATA_WIDTH     = rf_pkg::DATA_WIDTH,
    parameter int REG_NUM        = rf_pkg::REG_NUM,
    parameter int N_REQ          = 2
) (
    input  wire logic      clk,
    input  wire logic      rst,
    rf_wb_arbiter_if.slave bus
);

    import rf_pkg::*;

    localparam logic [REG_ADDR_WIDTH-1:0] C_X0 = REG_ADDR_WIDTH'(X0_IDX);

    logic [N_REQ-1:0]          w_grant;
    logic                      w_any_grant;
    logic [REG_ADDR_WIDTH-1:0] w_rd   [N_REQ];
    logic [DATA_WIDTH-1:0]     w_data [N_REQ];
    logic [REG_ADDR_WIDTH-1:0] w_sel_rd;
    logic [DATA_WIDTH-1:0]     w_sel_data;

    logic                      r_wen;
    logic [REG_ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0]     r_wdata;

    logic [REG_NUM-1:0]        r_busy;
    logic [REG_NUM-1:0]        w_busy_nxt;
    logic                      w_iss_ready;
    logic                      w_iss_fire;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_rd[gi]   = bus.req_rd[gi*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        assign w_data[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .grant   (w_grant),
        .advance (w_any_grant)
    );

    assign w_any_grant   = |w_grant;
    assign bus.req_ready = w_grant;

    always_comb begin
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_rd   = w_rd[i];
                w_sel_data = w_data[i];
            end
        end
    end

    // x0 writes are consumed like any other but never reach the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_any_grant) begin
            r_wen   <= (w_sel_rd != C_X0);
            r_waddr <= w_sel_rd;
            r_wdata <= w_sel_data;
        end else begin
            r_wen   <= 1'b0;
        end
    end

    assign w_iss_ready = !r_busy[bus.iss_rd];
    assign w_iss_fire  = bus.iss_valid && w_iss_ready && (bus.iss_rd != C_X0);

    // Clear tracks the registered write so busy drops as the file commits;
    // a set can never target the register being cleared.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_wen) begin
            w_busy_nxt[r_waddr] = 1'b0;
        end
        if (w_iss_fire) begin
            w_busy_nxt[bus.iss_rd] = 1'b1;
        end
        w_busy_nxt[C_X0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign bus.iss_ready = w_iss_ready;
    assign bus.rs1_busy  = r_busy[bus.rs1];
    assign bus.rs2_busy  = r_busy[bus.rs2];
    assign bus.rf_wen    = r_wen;
    assign bus.rf_waddr  = r_waddr;
    assign bus.rf_wdata  = r_wdata;

endmodule : rf_wb_arbiter
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wb_arbiter
// Description : Directed vector table plus randomized run against a
//               cycle-level reference model of the write-back arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    localparam int N  = 2;
    localparam int AW = REG_ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    rf_wb_arbiter #(
        .REG_ADDR_WIDTH (AW),
        .DATA_WIDTH     (DW),
        .REG_NUM        (REG_NUM),
        .N_REQ          (N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit            rst;
        logic [N-1:0]  v;
        logic [AW-1:0] rd0;
        logic [DW-1:0] d0;
        logic [AW-1:0] rd1;
        logic [DW-1:0] d1;
        bit            iv;
        logic [AW-1:0] ird;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [N-1:0]  e_ready;
        bit            e_iss;
        bit            e_rs1b;
        bit            e_rs2b;
        bit            e_wen;
        logic [AW-1:0] e_waddr;
        logic [DW-1:0] e_wdata;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            m_ptr;
    bit            m_busy [REG_NUM];
    bit            m_wen;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    int            m_last_grant;
    int            proto_cnt = 0;

    function automatic vec_t mk(bit r, logic [N-1:0] v, logic [AW-1:0] rd0, logic [DW-1:0] d0,
                                logic [AW-1:0] rd1, logic [DW-1:0] d1, bit iv, logic [AW-1:0] ird,
                                logic [AW-1:0] rs1, logic [AW-1:0] rs2, logic [N-1:0] e_ready,
                                bit e_iss, bit e_rs1b, bit e_rs2b, bit e_wen,
                                logic [AW-1:0] e_waddr, logic [DW-1:0] e_wdata);
        vec_t t;
        t.rst = r; t.v = v; t.rd0 = rd0; t.d0 = d0; t.rd1 = rd1; t.d1 = d1;
        t.iv = iv; t.ird = ird; t.rs1 = rs1; t.rs2 = rs2;
        t.e_ready = e_ready; t.e_iss = e_iss; t.e_rs1b = e_rs1b; t.e_rs2b = e_rs2b;
        t.e_wen = e_wen; t.e_waddr = e_waddr; t.e_wdata = e_wdata;
        return t;
    endfunction

    task automatic drive(input bit r, input logic [N-1:0] v, input logic [AW-1:0] rd0,
                         input logic [DW-1:0] d0, input logic [AW-1:0] rd1, input logic [DW-1:0] d1,
                         input bit iv, input logic [AW-1:0] ird, input logic [AW-1:0] rs1,
                         input logic [AW-1:0] rs2);
        rst           = r;
        bus.req_valid = v;
        bus.req_rd    = {rd1, rd0};
        bus.req_data  = {d1, d0};
        bus.iss_valid = iv;
        bus.iss_rd    = ird;
        bus.rs1       = rs1;
        bus.rs2       = rs2;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // First valid requester at or after the pointer, wrapping; -1 if none.
    function automatic int model_grant();
        logic [N-1:0] v;
        v = bus.req_valid;
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = model_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_wen = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        m_last_grant = -1;
    endtask

    // Applies the clock-edge rules to the model using the inputs now driven.
    task automatic model_update();
        int            g;
        bit            pre [REG_NUM];
        logic [AW-1:0] rd;
        logic [AW-1:0] ird;
        if (rst) begin
            model_reset();
            return;
        end
        g   = model_grant();
        pre = m_busy;
        ird = bus.iss_rd;
        if (m_wen) m_busy[m_waddr] = 1'b0;
        if (bus.iss_valid && !pre[ird] && ird != 0) m_busy[ird] = 1'b1;
        m_last_grant = g;
        if (g >= 0) begin
            rd = bus.req_rd[g*AW +: AW];
            if (rd != 0 && !pre[rd]) proto_cnt++;
            m_wen   = (rd != 0);
            m_waddr = rd;
            m_wdata = bus.req_data[g*DW +: DW];
            m_ptr   = (g + 1) % N;
        end else begin
            m_wen = 1'b0;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " req_ready"}, 64'(bus.req_ready), 64'(model_ready()));
        chk({tag, " iss_ready"}, 64'(bus.iss_ready), 64'(!m_busy[bus.iss_rd]));
        chk({tag, " rs1_busy"},  64'(bus.rs1_busy),  64'(m_busy[bus.rs1]));
        chk({tag, " rs2_busy"},  64'(bus.rs2_busy),  64'(m_busy[bus.rs2]));
        chk({tag, " rf_wen"},    64'(bus.rf_wen),    64'(m_wen));
        chk({tag, " rf_waddr"},  64'(bus.rf_waddr),  64'(m_waddr));
        chk({tag, " rf_wdata"},  64'(bus.rf_wdata),  64'(m_wdata));
    endtask

    task automatic next_cycle();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t          vecs [$];
    bit            pv   [N];
    logic [AW-1:0] prd  [N];
    logic [DW-1:0] pdat [N];

    initial begin
        // Reset cycle with every input active; state is unknown before the first edge.
        drive(1, 2'b11, 5'd1, 32'hA5A5_0001, 5'd2, 32'h5A5A_0002, 1, 5'd4, 5'd4, 5'd3);
        #1;
        next_cycle();

        //             rst v      rd0   d0            rd1   d1            iv ird   rs1   rs2     rdy  iss b1 b2 wen addr  data
        vecs.push_back(mk(1, 2'b11, 5'd1, 32'hA5A5_0001, 5'd2, 32'h5A5A_0002, 1, 5'd4, 5'd4, 5'd3, 2'b01, 1, 0, 0, 0, 5'd0, 32'h0));
        vecs.push_back(mk(0, 2'b11, 5'd1, 32'hA5A5_0001, 5'd2, 32'h5A5A_0002, 1, 5'd4, 5'd4, 5'd3, 2'b01, 1, 0, 0, 0, 5'd0, 32'h0));
        vecs.push_back(mk(1, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         0, 5'd0, 5'd4, 5'd1, 2'b00, 1, 1, 0, 1, 5'd1, 32'hA5A5_0001));
        vecs.push_back(mk(0, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         0, 5'd0, 5'd4, 5'd1, 2'b00, 1, 0, 0, 0, 5'd0, 32'h0));
        // basic path on x5
        vecs.push_back(mk(0, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         1, 5'd5, 5'd5, 5'd0, 2'b00, 1, 0, 0, 0, 5'd0, 32'h0));
        vecs.push_back(mk(0, 2'b01, 5'd5, 32'hDEADBEEF,  5'd0, 32'h0,         0, 5'd0, 5'd5, 5'd0, 2'b01, 1, 1, 0, 0, 5'd0, 32'h0));
        vecs.push_back(mk(0, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         0, 5'd0, 5'd5, 5'd0, 2'b00, 1, 1, 0, 1, 5'd5, 32'hDEADBEEF));
        vecs.push_back(mk(0, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         0, 5'd0, 5'd5, 5'd0, 2'b00, 1, 0, 0, 0, 5'd5, 32'hDEADBEEF));
        // round-robin with both requesters held valid
        vecs.push_back(mk(0, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         1, 5'd1, 5'd1, 5'd2, 2'b00, 1, 0, 0, 0, 5'd5, 32'hDEADBEEF));
        vecs.push_back(mk(0, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         1, 5'd2, 5'd1, 5'd2, 2'b00, 1, 1, 0, 0, 5'd5, 32'hDEADBEEF));
        vecs.push_back(mk(0, 2'b11, 5'd1, 32'h1111_1111, 5'd2, 32'h2222_2222, 0, 5'd0, 5'd1, 5'd2, 2'b10, 1, 1, 1, 0, 5'd5, 32'hDEADBEEF));
        vecs.push_back(mk(0, 2'b11, 5'd1, 32'h1111_1111, 5'd2, 32'h2222_2222, 0, 5'd0, 5'd1, 5'd2, 2'b01, 1, 1, 1, 1, 5'd2, 32'h2222_2222));
        vecs.push_back(mk(0, 2'b11, 5'd1, 32'h1111_1111, 5'd2, 32'h2222_2222, 0, 5'd0, 5'd1, 5'd2, 2'b10, 1, 1, 0, 1, 5'd1, 32'h1111_1111));
        vecs.push_back(mk(0, 2'b11, 5'd1, 32'h1111_1111, 5'd2, 32'h2222_2222, 0, 5'd0, 5'd1, 5'd2, 2'b01, 1, 0, 0, 1, 5'd2, 32'h2222_2222));
        vecs.push_back(mk(0, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         0, 5'd0, 5'd1, 5'd2, 2'b00, 1, 0, 0, 1, 5'd1, 32'h1111_1111));
        // WAW stall on x7, then set x8 while x7 clears
        vecs.push_back(mk(0, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         1, 5'd7, 5'd7, 5'd8, 2'b00, 1, 0, 0, 0, 5'd1, 32'h1111_1111));
        vecs.push_back(mk(0, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         1, 5'd7, 5'd7, 5'd8, 2'b00, 0, 1, 0, 0, 5'd1, 32'h1111_1111));
        vecs.push_back(mk(0, 2'b10, 5'd0, 32'h0,         5'd7, 32'h7777_7777, 1, 5'd7, 5'd7, 5'd8, 2'b10, 0, 1, 0, 0, 5'd1, 32'h1111_1111));
        vecs.push_back(mk(0, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         1, 5'd7, 5'd7, 5'd8, 2'b00, 0, 1, 0, 1, 5'd7, 32'h7777_7777));
        vecs.push_back(mk(0, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         1, 5'd7, 5'd7, 5'd8, 2'b00, 1, 0, 0, 0, 5'd7, 32'h7777_7777));
        vecs.push_back(mk(0, 2'b01, 5'd7, 32'h7070_7070, 5'd0, 32'h0,         0, 5'd0, 5'd7, 5'd8, 2'b01, 1, 1, 0, 0, 5'd7, 32'h7777_7777));
        vecs.push_back(mk(0, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         1, 5'd8, 5'd7, 5'd8, 2'b00, 1, 1, 0, 1, 5'd7, 32'h7070_7070));
        vecs.push_back(mk(0, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         0, 5'd0, 5'd7, 5'd8, 2'b00, 1, 0, 1, 0, 5'd7, 32'h7070_7070));
        // x0 write is granted but never enables the file
        vecs.push_back(mk(0, 2'b10, 5'd0, 32'h0,         5'd0, 32'h0000_1234, 1, 5'd0, 5'd0, 5'd8, 2'b10, 1, 0, 1, 0, 5'd7, 32'h7070_7070));
        vecs.push_back(mk(0, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         1, 5'd0, 5'd0, 5'd0, 2'b00, 1, 0, 0, 0, 5'd0, 32'h0000_1234));
        // reset with x3/x9/x8 pending and a grant in the reset cycle
        vecs.push_back(mk(0, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         1, 5'd3, 5'd3, 5'd9, 2'b00, 1, 0, 0, 0, 5'd0, 32'h0000_1234));
        vecs.push_back(mk(0, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         1, 5'd9, 5'd3, 5'd9, 2'b00, 1, 1, 0, 0, 5'd0, 32'h0000_1234));
        vecs.push_back(mk(1, 2'b01, 5'd3, 32'h3333_3333, 5'd0, 32'h0,         0, 5'd0, 5'd3, 5'd9, 2'b01, 1, 1, 1, 0, 5'd0, 32'h0000_1234));
        vecs.push_back(mk(0, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         0, 5'd0, 5'd3, 5'd9, 2'b00, 1, 0, 0, 0, 5'd0, 32'h0));
        vecs.push_back(mk(0, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         0, 5'd0, 5'd8, 5'd9, 2'b00, 1, 0, 0, 0, 5'd0, 32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].rd0, vecs[i].d0, vecs[i].rd1, vecs[i].d1,
                  vecs[i].iv, vecs[i].ird, vecs[i].rs1, vecs[i].rs2);
            #1;
            chk($sformatf("row%0d req_ready", i), 64'(bus.req_ready), 64'(vecs[i].e_ready));
            chk($sformatf("row%0d iss_ready", i), 64'(bus.iss_ready), 64'(vecs[i].e_iss));
            chk($sformatf("row%0d rs1_busy", i),  64'(bus.rs1_busy),  64'(vecs[i].e_rs1b));
            chk($sformatf("row%0d rs2_busy", i),  64'(bus.rs2_busy),  64'(vecs[i].e_rs2b));
            chk($sformatf("row%0d rf_wen", i),    64'(bus.rf_wen),    64'(vecs[i].e_wen));
            chk($sformatf("row%0d rf_waddr", i),  64'(bus.rf_waddr),  64'(vecs[i].e_waddr));
            chk($sformatf("row%0d rf_wdata", i),  64'(bus.rf_wdata),  64'(vecs[i].e_wdata));
            next_cycle();
        end

        // Randomized traffic: requesters only write registers that are pending
        // and not already in flight, and hold their request until granted.
        foreach (pv[i]) begin
            pv[i] = 1'b0; prd[i] = '0; pdat[i] = '0;
        end
        for (int c = 0; c < 3000; c++) begin
            bit r;
            if (m_last_grant >= 0) pv[m_last_grant] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && $urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 7) == 0) begin
                        pv[i] = 1'b1; prd[i] = '0; pdat[i] = $urandom;
                    end else begin
                        int start;
                        start = $urandom_range(1, REG_NUM - 1);
                        for (int j = 0; j < REG_NUM - 1 && !pv[i]; j++) begin
                            int reg_i;
                            bit taken;
                            reg_i = 1 + (start - 1 + j) % (REG_NUM - 1);
                            taken = m_wen && (int'(m_waddr) == reg_i);
                            for (int o = 0; o < N; o++) begin
                                if (o != i && pv[o] && int'(prd[o]) == reg_i) taken = 1'b1;
                            end
                            if (m_busy[reg_i] && !taken) begin
                                pv[i] = 1'b1; prd[i] = AW'(reg_i); pdat[i] = $urandom;
                            end
                        end
                    end
                end
            end
            r = ($urandom_range(0, 199) == 0);
            drive(r, {pv[1], pv[0]}, prd[0], pdat[0], prd[1], pdat[1],
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, REG_NUM - 1)),
                  AW'($urandom_range(0, REG_NUM - 1)), AW'($urandom_range(0, REG_NUM - 1)));
            #1;
            check_model($sformatf("rnd%0d", c));
            next_cycle();
            if (r) begin
                foreach (pv[i]) pv[i] = 1'b0;
            end
        end

        $display("note: %0d write-backs targeted a register with no pending write", proto_cnt);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rf_wb_arbiter
`default_nettype wire

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and scoreboard for the integer register file. It shares the register file's single write port among `N_REQ` write-back sources (port 0 is EXU, port 1 is LSU) using round-robin arbitration, and registers the winning write. It also tracks which architectural registers have an in-flight write, so the issue stage can detect RAW/WAW hazards. It sits between the execute/memory stages and the register file write port.

## Interface
- `REG_ADDR_WIDTH`, 5, register index width
- `DATA_WIDTH`, 32, data width
- `REG_NUM`, 32, number of architectural registers
- `N_REQ`, 2, number of write-back requesters
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  N_REQ  per-requester write request
- `req_ready`  out  N_REQ  per-requester grant; transfer when valid & ready
- `req_rd`  in  N_REQ*REG_ADDR_WIDTH  destination index, requester i at slice i
- `req_data`  in  N_REQ*DATA_WIDTH  write data, requester i at slice i
- `iss_valid`  in  1  issue stage allocates a destination
- `iss_rd`  in  REG_ADDR_WIDTH  destination being allocated
- `iss_ready`  out  1  allocation accepted
- `rs1`, `rs2`  in  REG_ADDR_WIDTH each  source indices to check
- `rs1_busy`, `rs2_busy`  out  1 each  source has a pending write
- `rf_wen`  out  1  register file write enable
- `rf_waddr`  out  REG_ADDR_WIDTH  register file write address
- `rf_wdata`  out  DATA_WIDTH  register file write data

## Operation
- **Arbitration**
  - Combinational round-robin over `req_valid`, starting from pointer `rr_ptr`.
  - At most one `req_ready` bit is high per cycle, and only on a valid requester.
  - No valid request means `req_ready` = 0.
- **Pointer update**
  - After a grant to requester i, `rr_ptr` becomes (i+1) mod N_REQ.
  - With no grant, the pointer holds.
- **Write register**
  - A grant loads `rf_wen` ← (rd ≠ 0), `rf_waddr` ← rd, `rf_wdata` ← data.
  - With no grant, `rf_wen` ← 0 and addr/data hold.
  - Writes to x0 are granted and consumed but never assert `rf_wen`.
- **Scoreboard**
  - `busy[REG_NUM]`, one bit per register. `busy[0]` is constant 0.
  - Set: `iss_valid & iss_ready & iss_rd≠0` sets `busy[iss_rd]`.
  - Clear: `rf_wen` high clears `busy[rf_waddr]` at the same edge the register file commits. The clear follows the registered write, not the grant.
  - `iss_ready` = !busy[iss_rd]. It is 1 for x0. A busy destination stalls issue (no WAW).
  - Same register set and cleared in one cycle cannot occur: the set requires busy=0, the clear implies busy=1.
  - Set and clear on different registers in the same cycle both take effect.
- **Source checks**
  - `rsN_busy` = busy[rsN], combinational.
  - A source that is clearing this cycle still reads busy=1. Results become visible one cycle later, when the register file holds the data; there is no bypass.
- **Protocol errors**
  - A write request whose rd is not busy is still written. The busy bit is unaffected.
  - The bench flags this as a protocol error.

## Timing
- **Reset** values: `rr_ptr`=0, all `busy`=0, `rf_wen`=0, `rf_waddr`=0, `rf_wdata`=0.
  - `req_ready` is combinational and follows `req_valid` from the first post-reset cycle.
- **Latency**
  - Grant at cycle t gives `rf_wen/waddr/wdata` valid in t+1.
  - The register file commits at the end of t+1.
  - `busy` clears at the end of t+1, so readers see busy=0 and correct data from t+2.
- **Throughput**: one write per cycle; no back-pressure from the register file.
- **Requester stall**: a requester not granted must hold valid/rd/data stable until granted.
- **Reset mid-operation**
  - All pending busy bits are dropped.
  - Any write registered in the reset cycle is suppressed (`rf_wen`=0 next cycle).

## Structure
- Shared package `rf_pkg`: `REG_ADDR_WIDTH`, `DATA_WIDTH`, `REG_NUM`, and the x0 index constant. The `regfile` block shares the same package.
- Sub-module `rr_arbiter #(N)`:
  - Ports: `clk`, `rst`, `req[N]`, `grant[N]` one-hot, `advance`.
  - Contains `rr_ptr` and rotate-priority logic.
- Top level holds the scoreboard, the write register, and the x0 masking.

## Test plan
- **Reset:** assert `rst` 2 cycles with all inputs active. Required: `rf_wen`=0, all busy=0, `iss_ready`=1, then first grant to requester 0.
- **Basic path:**
  - Issue rd=5.
  - EXU writes rd=5, data=0xDEADBEEF.
  - Required: `rs1_busy` (rs1=5) is 1 until t+1, `rf_wen`=1/addr 5/data 0xDEADBEEF at t+1, `rs1_busy`=0 at t+2.
- **Round-robin:** both requesters valid continuously (EXU rd=1, LSU rd=2, busy set). Required: grants alternate 0,1,0,1 with one `req_ready` per cycle.
- **WAW stall:**
  - Issue rd=7, then issue rd=7 again. Required: `iss_ready`=0 until the write to 7 commits, then 1.
  - Set rd=8 while rd=7 clears. Required: both take effect.
- **x0:** LSU write rd=0, data=0x1234. Required: granted, `rf_wen`=0; `iss_ready`=1 and `rs1_busy`=0 for x0 always.
- **Reset mid-flight:** busy on regs 3 and 9, grant pending in the same cycle as `rst`. Required: next cycle `rf_wen`=0, busy all 0.
